// File: rtl/clock_run_controller_pkg.sv
// clk_ctrl_pkg: run-state type and shared constants for the clock run controller
package clk_ctrl_pkg;
    typedef enum logic [1:0] {HALT, STEP, RUN} run_state_e;
    localparam int KEY_STEP = 2;
    localparam int KEY_RUN  = 1;
    localparam int KEY_FAST = 0;
    localparam int DIV_W    = 25;
endpackage

// File: rtl/clock_run_controller_key_debounce.sv
// key_debounce: synchronizes an active-low key, debounces it and emits a one-cycle press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          db_q;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q;

    // debounced level only follows the synchronized level after a full run of mismatching cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            db_q      <= 1'b1;
            db_prev_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            db_prev_q <= db_q;
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = db_prev_q & ~db_q;
endmodule

// File: rtl/clock_run_controller.sv
// clock_run_controller: halt/step/run sequencer emitting a one-cycle processor clock enable
module clock_run_controller
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SLOW_BASE       = 131072,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic       iCLK_50,
    input  logic       iRST_N,
    input  logic [2:0] iKEY,
    input  logic [7:0] iFDIV,
    input  logic       iBreak,
    input  logic       iTimerEn,
    output logic       oCLK_EN,
    output logic       oRunning,
    output logic       oFast,
    output logic       oTimeout
);
    logic [2:0]       press;
    logic [1:0]       brk_q;
    logic [1:0]       ten_q;
    run_state_e       state_q, state_d;
    logic             fast_q, fast_d;
    logic             tout_q, tout_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] f_w;
    logic [DIV_W-1:0] period;
    logic [31:0]      tmo_q, tmo_d;
    logic             tick;
    logic             brk;
    logic             tmo_hit;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk_i  (iCLK_50),
            .rst_ni (iRST_N),
            .key_i  (iKEY[k]),
            .press_o(press[k])
        );
    end

    // slow period is the divisor scaled by the power-of-two base; >= lets a shrinking divisor take effect at once
    assign f_w     = (iFDIV == 8'd0) ? DIV_W'(1) : DIV_W'(iFDIV);
    assign period  = fast_q ? f_w : DIV_W'(f_w * DIV_W'(SLOW_BASE));
    assign tick    = div_q >= period - 1'b1;
    assign brk     = brk_q[1];
    assign tmo_hit = ten_q[1] && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    assign oCLK_EN  = (state_q == STEP) || ((state_q == RUN) && tick);
    assign oRunning = state_q == RUN;
    assign oFast    = fast_q;
    assign oTimeout = tout_q;

    // next-state: HALT prefers run over step, RUN exits on break > timeout > run press
    always_comb begin
        state_d = state_q;
        tout_d  = tout_q;
        if (state_q == HALT) begin
            if (press[KEY_RUN] && !brk) begin
                state_d = RUN;
                tout_d  = 1'b0;
            end else if (press[KEY_STEP]) begin
                state_d = STEP;
            end
        end else if (state_q == STEP) begin
            state_d = HALT;
        end else if (brk) begin
            state_d = HALT;
        end else if (tmo_hit) begin
            state_d = HALT;
            tout_d  = 1'b1;
        end else if (press[KEY_RUN]) begin
            state_d = HALT;
        end
        fast_d = fast_q ^ press[KEY_FAST];
        div_d  = (state_q != RUN || press[KEY_FAST] || tick) ? '0 : div_q + 1'b1;
        tmo_d  = (state_q != RUN) ? '0 : ten_q[1] ? tmo_q + 32'd1 : tmo_q;
    end

    // all sequencer state, rate divider, timeout counter and level synchronizers
    always_ff @(posedge iCLK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= HALT;
            fast_q  <= 1'b0;
            tout_q  <= 1'b0;
            div_q   <= '0;
            tmo_q   <= '0;
            brk_q   <= '0;
            ten_q   <= '0;
        end else begin
            state_q <= state_d;
            fast_q  <= fast_d;
            tout_q  <= tout_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
            brk_q   <= {brk_q[0], iBreak};
            ten_q   <= {ten_q[0], iTimerEn};
        end
    end
endmodule

// File: tb/tb_clock_run_controller.sv
// tb_clock_run_controller: directed scenarios plus random keys/break/timer checked against a reference model
module tb_clock_run_controller;
    import clk_ctrl_pkg::*;

    localparam int N    = 4;
    localparam int SB   = 8;
    localparam int TO   = 100;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key = 3'b111;
    logic [7:0] fdiv = 8'd1;
    logic       brk = 1'b0;
    logic       ten = 1'b0;
    logic       clk_en, running, fast, tout;

    clock_run_controller #(
        .DEBOUNCE_CYCLES(N),
        .SLOW_BASE      (SB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iCLK_50 (clk),
        .iRST_N  (rst_n),
        .iKEY    (key),
        .iFDIV   (fdiv),
        .iBreak  (brk),
        .iTimerEn(ten),
        .oCLK_EN (clk_en),
        .oRunning(running),
        .oFast   (fast),
        .oTimeout(tout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int t = 0;
    bit bh[MAXC];
    bit th[MAXC];
    int ev_s[$];
    int ev_r[$];
    int ev_f[$];
    // model: mode 0=halted 1=single step 2=running; age = RUN cycles since entry or rate toggle
    int m_mode = 0;
    bit m_fast = 0;
    bit m_tout = 0;
    int m_age = 0;
    int m_en = 0;
    int pulses = 0;
    int first_pulse = -1;
    int last_pulse = -1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // a clean hold of >= N cycles yields a press the FSM acts on N+2 edges after the first low sample
    task automatic sched(input int k, input int e);
        if (k == KEY_STEP) ev_s.push_back(e);
        else if (k == KEY_RUN) ev_r.push_back(e);
        else ev_f.push_back(e);
    endtask

    task automatic cyc(input int n);
        bit se, re, fe, b, e;
        int f, p;
        bit exp_en;
        for (int i = 0; i < n; i++) begin
            bh[t] = brk;
            th[t] = ten;
            @(posedge clk);
            #1;
            se = (ev_s.size() != 0) && (ev_s[0] == t);
            re = (ev_r.size() != 0) && (ev_r[0] == t);
            fe = (ev_f.size() != 0) && (ev_f[0] == t);
            if (se) void'(ev_s.pop_front());
            if (re) void'(ev_r.pop_front());
            if (fe) void'(ev_f.pop_front());
            b = (t >= 2) ? bh[t-2] : 1'b0;
            e = (t >= 2) ? th[t-2] : 1'b0;
            if (m_mode == 0) begin
                if (re && !b) begin
                    m_mode = 2; m_tout = 0; m_age = 0; m_en = 0;
                end else if (se) m_mode = 1;
            end else if (m_mode == 1) m_mode = 0;
            else if (b) m_mode = 0;
            else if (e && m_en == TO - 1) begin
                m_mode = 0; m_tout = 1;
            end else if (re) m_mode = 0;
            else begin
                m_age = fe ? 0 : m_age + 1;
                m_en += int'(e);
            end
            if (fe) m_fast = !m_fast;
            f = (fdiv == 0) ? 1 : int'(fdiv);
            p = m_fast ? f : f * SB;
            exp_en = (m_mode == 1) || (m_mode == 2 && (m_age % p) == p - 1);
            chk("clk_en", clk_en, exp_en);
            chk("running", running, m_mode == 2);
            chk("fast", fast, m_fast);
            chk("timeout", tout, m_tout);
            if (clk_en) begin
                if (pulses == 0) first_pulse = t;
                pulses++;
                last_pulse = t;
            end
            t++;
        end
    endtask

    task automatic press(input int k, input int len, input int gap);
        key[k] = 1'b0;
        if (len >= N) sched(k, t + N + 2);
        cyc(len);
        key[k] = 1'b1;
        cyc(gap);
    endtask

    initial begin
        int t0;
        int lo[3];
        int gp[3];
        int len;
        #3;
        chk("rst_clk_en", clk_en, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_fast", fast, 1'b0);
        chk("rst_timeout", tout, 1'b0);
        #9 rst_n = 1'b1;
        cyc(4);
        // single step and a bounced key
        pulses = 0; t0 = t;
        press(KEY_STEP, 20, 10);
        chk_i("step_pulses", pulses, 1);
        chk_i("step_latency", last_pulse - t0, N + 2);
        pulses = 0;
        press(KEY_STEP, 2, 10);
        chk_i("bounce_pulses", pulses, 0);
        // fast run at divisor 3, then divisor 0
        press(KEY_FAST, 6, 8);
        fdiv = 8'd3; pulses = 0; t0 = t;
        press(KEY_RUN, 6, 30);
        chk_i("run3_first", first_pulse - t0, N + 4);
        chk_i("run3_pulses", pulses, 10);
        fdiv = 8'd0; pulses = 0;
        cyc(10);
        chk_i("div0_pulses", pulses, 10);
        press(KEY_RUN, 6, 10);
        // slow run at divisor 2, then switch to fast mid-run
        press(KEY_FAST, 6, 10);
        fdiv = 8'd2; pulses = 0;
        press(KEY_RUN, 6, 60);
        chk_i("slow_pulses", pulses, 3);
        press(KEY_FAST, 7, 0);
        pulses = 0;
        cyc(20);
        chk_i("fast_mid_pulses", pulses, 10);
        press(KEY_RUN, 6, 10);
        // break stops a run and blocks a new one
        fdiv = 8'd1;
        press(KEY_RUN, 6, 10);
        brk = 1'b1;
        cyc(3);
        chk("brk_running", running, 1'b0);
        chk("brk_clk_en", clk_en, 1'b0);
        press(KEY_RUN, 6, 10);
        chk("brk_blocked", running, 1'b0);
        brk = 1'b0;
        cyc(4);
        // run timeout
        ten = 1'b1;
        cyc(3);
        pulses = 0;
        press(KEY_RUN, 6, 120);
        chk_i("tmo_pulses", pulses, TO);
        chk("tmo_flag", tout, 1'b1);
        chk("tmo_halted", running, 1'b0);
        press(KEY_RUN, 6, 10);
        chk("tmo_cleared", tout, 1'b0);
        chk("tmo_rerun", running, 1'b1);
        // asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("arst_running", running, 1'b0);
        chk("arst_clk_en", clk_en, 1'b0);
        chk("arst_fast", fast, 1'b0);
        chk("arst_timeout", tout, 1'b0);
        ten = 1'b0; key = 3'b111;
        ev_s.delete(); ev_r.delete(); ev_f.delete();
        m_mode = 0; m_fast = 0; m_tout = 0; m_age = 0; m_en = 0; t = 0;
        #20 rst_n = 1'b1;
        pulses = 0;
        cyc(20);
        chk_i("arst_no_pulses", pulses, 0);
        // random keys, break, timer enable and divisor
        for (int k = 0; k < 3; k++) begin
            lo[k] = 0; gp[k] = 0;
        end
        ten = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (lo[k] > 0) begin
                    lo[k]--;
                    if (lo[k] == 0) begin
                        key[k] = 1'b1;
                        gp[k] = N + 3;
                    end
                end else if (gp[k] > 0) gp[k]--;
                else if ($urandom_range(0, 29) == 0) begin
                    len = $urandom_range(1, 10);
                    key[k] = 1'b0;
                    lo[k] = len;
                    if (len >= N) sched(k, t + N + 2);
                end
            end
            if ($urandom_range(0, 59) == 0) brk = !brk;
            if ($urandom_range(0, 79) == 0) ten = !ten;
            if (m_mode == 0 && $urandom_range(0, 19) == 0) fdiv = 8'($urandom_range(0, 4));
            cyc(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_run_controller.md
Name: clock_run_controller

Overview:
- Run-control sequencer for the processor clock.
- Replaces the gated manual/auto clock mux with a single-clock design that emits a one-cycle clock-enable pulse (oCLK_EN) for the processor core.
- Sequences halt / single-step / free-run from debounced board keys, the break input and a run timeout, at a slow or fast rate set by the frequency divisor.
- Sits between the board keys / debug logic and the processor's clock-enable input.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles a key must be stable before its debounced level changes (5 ms at 50 MHz)
SLOW_BASE, 131072, slow-mode multiplier applied to the divisor (power of two)
TIMEOUT_CYCLES, 500000000, RUN cycles before an automatic halt when the timer is enabled (10 s at 50 MHz)

Ports:
iCLK_50  in  1  system clock, 50 MHz
iRST_N  in  1  reset, asynchronous, active-low
iKEY  in  3  active-low buttons: [2] step, [1] run/halt toggle, [0] slow/fast toggle
iFDIV  in  8  rate divisor; 0 is treated as 1
iBreak  in  1  break request, asynchronous level
iTimerEn  in  1  enables the run timeout, asynchronous level
oCLK_EN  out  1  one-cycle processor clock enable
oRunning  out  1  1 while the FSM is in RUN
oFast  out  1  1 when fast rate is selected
oTimeout  out  1  sticky: last halt was caused by the timeout

Behaviour:
- One clock (iCLK_50). Reset is asynchronous and active-low (iRST_N); polarity and synchronicity are fixed.
- Reset values:
  - FSM = HALT.
  - oCLK_EN, oRunning, oFast, oTimeout = 0.
  - Debounced keys = 1 (released).
  - All counters = 0.
  - Synchronizers = 1 for keys, 0 for iBreak and iTimerEn.
- Input synchronization: iKEY, iBreak and iTimerEn each pass through a 2-flop synchronizer.
- Debounce:
  - The debounced level follows the synchronized level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears the count.
  - A press event is a single-cycle 1->0 transition of the debounced level.
  - Press-to-event latency = 2 + DEBOUNCE_CYCLES cycles; the FSM reacts on the following edge.
- Rate:
  - F = max(iFDIV, 1).
  - Period P = F when oFast = 1; P = F*SLOW_BASE when oFast = 0.
  - The divider counter is 25 bits wide and is cleared on RUN entry and on every fast/slow toggle.
  - A tick is asserted when counter >= P-1, after which the counter wraps to 0. The >= comparison makes a mid-run iFDIV reduction take effect without overrun.
- FSM states HALT, STEP, RUN:
  - HALT:
    - Step press -> STEP.
    - Run press with synchronized break = 0 -> RUN; also clears oTimeout.
    - Run press with break = 1 is ignored.
  - STEP: oCLK_EN = 1 for exactly one cycle, then unconditionally -> HALT.
  - RUN:
    - oCLK_EN = tick.
    - First pulse occurs in the P-th cycle of RUN.
    - Exits to HALT on break, on timeout, or on a run press.
    - Step presses are ignored.
- Exit priority in RUN: break > timeout > run press.
- In HALT, simultaneous step and run presses: run wins.
- A fast/slow press toggles oFast in any state, including the same cycle as other presses.
- Timeout:
  - The counter increments each RUN cycle while the synchronized iTimerEn = 1.
  - When it reaches TIMEOUT_CYCLES-1: -> HALT and oTimeout <= 1.
  - The counter clears whenever not in RUN, and holds while iTimerEn = 0.
- oCLK_EN is never asserted in HALT. On any transition to HALT, oCLK_EN = 0 from the first HALT cycle.
- Mid-operation reset: all outputs go to their reset values immediately and asynchronously, with no clock edge required.

Decomposition:
- Package clk_ctrl_pkg holds:
  - Run-state enumerated type: HALT, STEP, RUN.
  - Key index constants: KEY_STEP = 2, KEY_RUN = 1, KEY_FAST = 0.
  - Divider width constant 25.
- One sub-module, key_debounce: 2-flop synchronizer + stability counter + falling-edge press pulse. Instantiated 3 times, parameterized by DEBOUNCE_CYCLES.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SLOW_BASE=8, TIMEOUT_CYCLES=100.
1. Step key low for 20 cycles -> exactly one oCLK_EN pulse, 7 cycles after the falling edge; FSM returns to HALT. Key low for 2 cycles (bounce) -> no pulse.
2. Fast selected, iFDIV=3, run press -> oRunning=1; oCLK_EN pulses every 3 cycles, first in the 3rd RUN cycle. Then iFDIV=0 -> oCLK_EN high every cycle.
3. Slow selected, iFDIV=2, RUN -> pulse period 16 cycles. Fast press mid-run -> counter restarts; period 2 thereafter.
4. iBreak=1 while running -> oCLK_EN=0 and oRunning=0 within 3 cycles of the assertion. Run press while iBreak=1 -> stays HALT.
5. iTimerEn=1, fast, iFDIV=1 -> 100 RUN cycles then HALT, oTimeout=1. Next run press -> oTimeout=0, RUN.
6. Assert iRST_N=0 mid-RUN between clock edges -> oRunning, oCLK_EN, oFast, oTimeout all 0 immediately. Release -> HALT with no pulses.
